// File: rtl/pc_seq_pkg.sv
// Shared picoMIPS definitions for the program-counter sequencer:
// memory width, default return-stack depth and the decoded PC operation.
package picoMIPS_package;

    localparam int PMEM_WIDTH     = 8;
    localparam int PC_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        INC  = 3'd1,
        BR   = 3'd2,
        JMP  = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } pc_op_t;

    // With the stack compiled out, call/ret fall through to the remaining inputs.
    function automatic pc_op_t pc_decode(
        input logic stack_en,
        input logic inc,
        input logic jmp,
        input logic br,
        input logic call,
        input logic ret
    );
        pc_op_t op;
        if (stack_en && ret) begin
            op = RET;
        end else if (stack_en && call) begin
            op = CALL;
        end else if (jmp) begin
            op = JMP;
        end else if (br) begin
            op = BR;
        end else if (inc) begin
            op = INC;
        end else begin
            op = HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_seq_stack.sv
// LIFO return-address stack for pc_seq; only the occupancy count is reset,
// entry data is left as-is.
module pc_stack
    import picoMIPS_package::*;
#(
    parameter int W     = PMEM_WIDTH,
    parameter int DEPTH = PC_STACK_DEPTH
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] top_idx_s;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & ~full & ~pop;
    // A full stack has zero low count bits, so count-1 still lands on DEPTH-1.
    assign top_idx_s = count_q[PTR_W-1:0] - PTR_W'(1);
    assign dout      = mem_q[top_idx_s];

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (do_pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else if (do_push_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[count_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with priority ret > call > jmp > br > inc.
// The return stack and its sticky flags exist only when PC_SEQ_STACK_EN is defined.
module pc_seq
    import picoMIPS_package::*;
#(
    parameter int              ADDR_W      = PMEM_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}},
    parameter int              STACK_DEPTH = PC_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              inc,
    input  logic              jmp,
    input  logic              br,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] addr,
    output logic              stk_ovf,
    output logic              stk_unf
);

`ifdef PC_SEQ_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    pc_op_t            op_s;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_inc_s;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic [ADDR_W-1:0] stk_dout_s;
    logic              stk_full_s;
    logic              stk_empty_s;

    assign op_s       = pc_decode(STACK_EN, inc, jmp, br, call, ret);
    assign addr_inc_s = addr_q + ADDR_W'(1);

`ifdef PC_SEQ_STACK_EN
    logic push_s;
    logic pop_s;

    assign push_s = (op_s == CALL);
    assign pop_s  = (op_s == RET);

    pc_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .nRst  (nRst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (addr_inc_s),
        .dout  (stk_dout_s),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
`else
    logic unused_s;

    assign stk_dout_s  = {ADDR_W{1'b0}};
    assign stk_full_s  = 1'b0;
    assign stk_empty_s = 1'b1;
    assign stk_ovf     = 1'b0;
    assign stk_unf     = 1'b0;
    assign unused_s    = ovf_q ^ unf_q ^ STACK_DEPTH[0];
`endif

    // Next address and flag computation
    always_comb begin
        addr_d = addr_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        case (op_s)
            INC:  addr_d = addr_inc_s;
            BR:   addr_d = addr_q + offset;
            JMP:  addr_d = target;
            CALL: begin
                addr_d = target;
                if (stk_full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            RET: begin
                if (stk_empty_s) begin
                    addr_d = addr_inc_s;
                    unf_d  = 1'b1;
                end else begin
                    addr_d = stk_dout_s;
                    unf_d  = unf_q;
                end
            end
            HOLD:    addr_d = addr_q;
            default: addr_d = addr_q;
        endcase
    end

    // Address and sticky flag registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            addr_q <= RESET_ADDR;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign addr = addr_q;

endmodule
